// File: rtl/mf_scale_cntr_bank.sv
// Bank of programmable clock-scale counters with shadowed configuration.
// Define MF_SCALE_CNTR_PHASE_STEP_EN to compile in LOW-phase stepping.
module mf_scale_cntr_bank #(
  parameter int NUM_CNTR  = 5,
  parameter int CNT_WIDTH = 8,
  parameter int SEL_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [SEL_WIDTH-1:0] cfg_sel,
  input  logic [CNT_WIDTH-1:0] cfg_high,
  input  logic [CNT_WIDTH-1:0] cfg_low,
  input  logic [CNT_WIDTH-1:0] cfg_init,
  input  logic [1:0]           cfg_mode,
  input  logic                 phase_step,
  input  logic [SEL_WIDTH-1:0] phase_sel,
  input  logic                 phase_up,
  output logic                 phase_done,
  output logic                 phase_err,
  output logic [NUM_CNTR-1:0]  cout,
  output logic [NUM_CNTR-1:0]  period_start
);

  localparam int CW = CNT_WIDTH + 1;
  localparam logic [1:0] M_OFF   = 2'b00;
  localparam logic [1:0] M_NORM  = 2'b01;
  localparam logic [1:0] M_PULSE = 2'b10;
  localparam logic [1:0] M_HOLD  = 2'b11;

  typedef logic [CW-1:0] cnt_t;

  typedef struct packed {
    logic [1:0]           mode;
    logic [CNT_WIDTH-1:0] high;
    logic [CNT_WIDTH-1:0] low;
    logic [CNT_WIDTH-1:0] init;
  } cfg_t;

  typedef enum logic [1:0] {
    S_IDLE, S_DELAY, S_HIGH, S_LOW
  } st_e;

  function automatic cnt_t eff(
    input logic [CNT_WIDTH-1:0] v
  );
    return (v == '0) ? cnt_t'(1) : {1'b0, v};
  endfunction

  st_e  st_q  [NUM_CNTR];
  st_e  st_d  [NUM_CNTR];
  cnt_t cnt_q [NUM_CNTR];
  cnt_t cnt_d [NUM_CNTR];
  cfg_t act_q [NUM_CNTR];
  cfg_t act_d [NUM_CNTR];
  cfg_t shd_q [NUM_CNTR];
  cfg_t shd_d [NUM_CNTR];
  cnt_t hi_eff  [NUM_CNTR];
  cnt_t lo_eff  [NUM_CNTR];
  cnt_t lo_term [NUM_CNTR];

  logic [NUM_CNTR-1:0] pend_q, pend_d;
  logic [NUM_CNTR-1:0] cout_q, cout_d;
  logic [NUM_CNTR-1:0] pst_q, pst_d;
  logic [NUM_CNTR-1:0] run, hold;
  logic [NUM_CNTR-1:0] last_low;
  logic [NUM_CNTR-1:0] wr_hit, copy;
  cfg_t                cfg_in;

`ifdef MF_SCALE_CNTR_PHASE_STEP_EN
  logic [NUM_CNTR-1:0] busy_q, busy_d;
  logic [NUM_CNTR-1:0] live_q, live_d;
  logic [NUM_CNTR-1:0] up_q, up_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
`endif

  always_comb begin
    cfg_in.mode = cfg_mode;
    cfg_in.high = cfg_high;
    cfg_in.low  = cfg_low;
    cfg_in.init = cfg_init;
    cfg_ready   = 1'b1;
    for (int i = 0; i < NUM_CNTR; i++) begin
      if (cfg_sel == SEL_WIDTH'(i)) begin
        cfg_ready = !pend_q[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CNTR; i++) begin
      hi_eff[i]  = eff(act_q[i].high);
      lo_eff[i]  = eff(act_q[i].low);
      lo_term[i] = lo_eff[i];
`ifdef MF_SCALE_CNTR_PHASE_STEP_EN
      if (busy_q[i] && live_q[i]) begin
        if (up_q[i]) begin
          lo_term[i] = lo_eff[i] + cnt_t'(1);
        end else if (lo_eff[i] > cnt_t'(1)) begin
          lo_term[i] = lo_eff[i] - cnt_t'(1);
        end
      end
`endif
      run[i]  = (act_q[i].mode == M_NORM) ||
                (act_q[i].mode == M_PULSE);
      hold[i] = act_q[i].mode == M_HOLD;
      last_low[i] = (st_q[i] == S_LOW) &&
                    (cnt_q[i] + cnt_t'(1) >= lo_term[i]);
      wr_hit[i] = cfg_valid && !pend_q[i] &&
                  (cfg_sel == SEL_WIDTH'(i));
      // HOLD writes, and writes while holding, land at once
      copy[i] = pend_q[i] &&
                (st_q[i] == S_IDLE || st_q[i] == S_DELAY ||
                 last_low[i] || hold[i] ||
                 shd_q[i].mode == M_HOLD);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CNTR; i++) begin
        st_q[i]  <= S_IDLE;
        cnt_q[i] <= '0;
        act_q[i] <= '0;
        shd_q[i] <= '0;
      end
      pend_q <= '0;
      cout_q <= '0;
      pst_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_CNTR; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
        act_q[i] <= act_d[i];
        shd_q[i] <= shd_d[i];
      end
      pend_q <= pend_d;
      cout_q <= cout_d;
      pst_q  <= pst_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CNTR; i++) begin
      st_d[i]   = st_q[i];
      cnt_d[i]  = cnt_q[i];
      act_d[i]  = act_q[i];
      shd_d[i]  = shd_q[i];
      pend_d[i] = pend_q[i];
      if (run[i]) begin
        unique case (st_q[i])
          S_IDLE: begin
            st_d[i]  = (act_q[i].init != '0) ? S_DELAY : S_HIGH;
            cnt_d[i] = '0;
          end
          S_DELAY: begin
            if (cnt_q[i] + cnt_t'(1) >= {1'b0, act_q[i].init}) begin
              st_d[i]  = S_HIGH;
              cnt_d[i] = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + cnt_t'(1);
            end
          end
          S_HIGH: begin
            if (cnt_q[i] + cnt_t'(1) >= hi_eff[i]) begin
              st_d[i]  = S_LOW;
              cnt_d[i] = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + cnt_t'(1);
            end
          end
          S_LOW: begin
            if (last_low[i]) begin
              st_d[i]  = S_HIGH;
              cnt_d[i] = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + cnt_t'(1);
            end
          end
          default: st_d[i] = S_IDLE;
        endcase
      end else if (!hold[i]) begin
        st_d[i]  = S_IDLE;
        cnt_d[i] = '0;
      end
      if (copy[i]) begin
        act_d[i]  = shd_q[i];
        pend_d[i] = 1'b0;
        if (shd_q[i].mode == M_OFF) begin
          st_d[i]  = S_IDLE;
          cnt_d[i] = '0;
        end else if (!hold[i] && shd_q[i].mode != M_HOLD) begin
          st_d[i]  = (shd_q[i].init != '0) ? S_DELAY : S_HIGH;
          cnt_d[i] = '0;
        end
      end
      if (wr_hit[i]) begin
        shd_d[i]  = cfg_in;
        pend_d[i] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CNTR; i++) begin
      cout_d[i] = 1'b0;
      pst_d[i]  = 1'b0;
      unique case (1'b1)
        hold[i]: cout_d[i] = cout_q[i];
        act_q[i].mode == M_NORM: begin
          cout_d[i] = st_q[i] == S_HIGH;
          pst_d[i]  = (st_q[i] == S_HIGH) && (cnt_q[i] == '0);
        end
        act_q[i].mode == M_PULSE: begin
          cout_d[i] = (st_q[i] == S_HIGH) && (cnt_q[i] == '0);
          pst_d[i]  = cout_d[i];
        end
        default: ;
      endcase
    end
  end

  assign cout         = cout_q;
  assign period_start = pst_q;

`ifdef MF_SCALE_CNTR_PHASE_STEP_EN
  always_comb begin
    done_d = 1'b0;
    err_d  = 1'b0;
    for (int i = 0; i < NUM_CNTR; i++) begin
      busy_d[i] = busy_q[i];
      live_d[i] = live_q[i];
      up_d[i]   = up_q[i];
      if (busy_q[i] && run[i] && last_low[i]) begin
        if (live_q[i]) begin
          busy_d[i] = 1'b0;
          live_d[i] = 1'b0;
          done_d    = 1'b1;
        end else begin
          live_d[i] = 1'b1;
        end
      end
      if (!run[i] && !hold[i]) begin
        busy_d[i] = 1'b0;
        live_d[i] = 1'b0;
      end
      if (phase_step && phase_sel == SEL_WIDTH'(i)) begin
        if (!run[i] || busy_q[i] ||
            (!phase_up && lo_eff[i] == cnt_t'(1))) begin
          err_d = 1'b1;
        end else begin
          busy_d[i] = 1'b1;
          up_d[i]   = phase_up;
          // a step-down mid-LOW waits for the following LOW
          live_d[i] = phase_up || st_q[i] != S_LOW ||
                      last_low[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= '0;
      live_q <= '0;
      up_q   <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      live_q <= live_d;
      up_q   <= up_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  assign phase_done = done_q;
  assign phase_err  = err_q;
`else
  logic unused_phase;
  assign unused_phase = ^{phase_step, phase_sel, phase_up};
  assign phase_done   = 1'b0;
  assign phase_err    = 1'b0;
`endif

endmodule

// File: tb/tb_mf_scale_cntr_bank.sv
// Directed bench for mf_scale_cntr_bank.
// Honours MF_SCALE_CNTR_PHASE_STEP_EN like the design.
module tb_mf_scale_cntr_bank;

  localparam int N  = 5;
  localparam int W  = 8;
  localparam int SW = 3;
  localparam logic [1:0] M_NORM  = 2'b01;
  localparam logic [1:0] M_PULSE = 2'b10;
  localparam logic [1:0] M_HOLD  = 2'b11;

  logic          clk;
  logic          reset_n;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [SW-1:0] cfg_sel;
  logic [W-1:0]  cfg_high;
  logic [W-1:0]  cfg_low;
  logic [W-1:0]  cfg_init;
  logic [1:0]    cfg_mode;
  logic          phase_step;
  logic [SW-1:0] phase_sel;
  logic          phase_up;
  logic          phase_done;
  logic          phase_err;
  logic [N-1:0]  cout;
  logic [N-1:0]  period_start;

  int errs   = 0;
  int checks = 0;
  int cyc    = 0;
  int w2     = 0;

  mf_scale_cntr_bank #(
    .NUM_CNTR (N),
    .CNT_WIDTH(W),
    .SEL_WIDTH(SW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_sel     (cfg_sel),
    .cfg_high    (cfg_high),
    .cfg_low     (cfg_low),
    .cfg_init    (cfg_init),
    .cfg_mode    (cfg_mode),
    .phase_step  (phase_step),
    .phase_sel   (phase_sel),
    .phase_up    (phase_up),
    .phase_done  (phase_done),
    .phase_err   (phase_err),
    .cout        (cout),
    .period_start(period_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic cfg_wr(
    input logic [SW-1:0] sel,
    input logic [W-1:0]  h,
    input logic [W-1:0]  l,
    input logic [W-1:0]  i,
    input logic [1:0]    m
  );
    int n;
    cfg_sel   = sel;
    cfg_high  = h;
    cfg_low   = l;
    cfg_init  = i;
    cfg_mode  = m;
    cfg_valid = 1'b1;
    n = 0;
    while (!cfg_ready && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) check("wr_timeout", 32'(cfg_ready), 1);
    tick();
    cfg_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    reset_n    = 1'b0;
    cfg_valid  = 1'b0;
    cfg_sel    = '0;
    cfg_high   = '0;
    cfg_low    = '0;
    cfg_init   = '0;
    cfg_mode   = '0;
    phase_step = 1'b0;
    phase_sel  = '0;
    phase_up   = 1'b0;
    repeat (2) tick();
    check("rst_cout", 32'(cout), 0);
    check("rst_pst", 32'(period_start), 0);
    check("rst_rdy", 32'(cfg_ready), 1);
    check("rst_done", 32'(phase_done), 0);
    check("rst_err", 32'(phase_err), 0);
    reset_n = 1'b1;
    repeat (3) tick();
    check("off_cout", 32'(cout), 0);

    // counter 0: NORMAL 2/3, init 4
    cfg_wr(0, 2, 3, 4, M_NORM);
    for (int k = 1; k <= 15; k++) begin
      tick();
      p = (k >= 6) ? (k - 6) % 5 : 9;
      check("t30_cout", 32'(cout[0]), 32'(p < 2));
      check("t30_pst", 32'(period_start[0]), 32'(p == 0));
    end

`ifdef MF_SCALE_CNTR_PHASE_STEP_EN
    phase_sel  = 0;
    phase_up   = 1'b1;
    phase_step = 1'b1;
    tick();
    phase_step = 1'b0;
    for (int j = 0; j < 12; j++) begin
      int e;
      if (j > 0) tick();
      if (j < 2) e = 1;
      else if (j < 6) e = 0;
      else e = ((j - 6) % 5 < 2) ? 1 : 0;
      check("up_cout", 32'(cout[0]), 32'(e));
      check("up_done", 32'(phase_done), 32'(j == 5));
      check("up_err", 32'(phase_err), 32'(j == 2));
      phase_step = (j == 1);
    end
`else
    phase_sel  = 0;
    phase_up   = 1'b1;
    phase_step = 1'b1;
    for (int k = 16; k <= 22; k++) begin
      tick();
      phase_step = 1'b0;
      p = (k - 6) % 5;
      check("nph_cout", 32'(cout[0]), 32'(p < 2));
      check("nph_done", 32'(phase_done), 0);
      check("nph_err", 32'(phase_err), 0);
    end
`endif

    // counter 1: PULSE 1/3
    cfg_wr(1, 1, 3, 0, M_PULSE);
    for (int k = 1; k <= 10; k++) begin
      tick();
      p = (k >= 2 && (k - 2) % 4 == 0) ? 1 : 0;
      check("t31_pulse", 32'(cout[1]), 32'(p));
      check("t31_pst", 32'(period_start[1]), 32'(p));
    end

    // counter 2: zero fields toggle every cycle
    cfg_wr(2, 0, 0, 0, M_NORM);
    w2 = cyc;
    for (int k = 0; k < 6; k++) begin
      tick();
      p = cyc - w2;
      check("t31_tog", 32'(cout[2]), 32'(p >= 2 && p % 2 == 0));
    end
`ifdef MF_SCALE_CNTR_PHASE_STEP_EN
    phase_sel  = 2;
    phase_up   = 1'b0;
    phase_step = 1'b1;
    tick();
    phase_step = 1'b0;
    check("dn_err1", 32'(phase_err), 1);
    tick();
    check("dn_err0", 32'(phase_err), 0);
    check("dn_done", 32'(phase_done), 0);
`endif
    for (int k = 0; k < 4; k++) begin
      tick();
      p = cyc - w2;
      check("t33_tog", 32'(cout[2]), 32'(p % 2 == 0));
    end

    // counter 3: second write waits for the period boundary
    cfg_wr(3, 2, 3, 0, M_NORM);
    cfg_wr(3, 4, 4, 0, M_NORM);
    check("t32_rdy0", 32'(cfg_ready), 0);
    for (int k = 1; k <= 13; k++) begin
      tick();
      p = (k == 1 || (k >= 5 && k <= 8) || k == 13) ? 1 : 0;
      check("t32_cout", 32'(cout[3]), 32'(p));
      check("t32_rdy", 32'(cfg_ready), 32'(k >= 4));
      check("t32_pst", 32'(period_start[3]), 32'(k == 5 || k == 13));
    end

    // counter 4: HOLD during HIGH, then resume
    cfg_wr(4, 5, 2, 0, M_NORM);
    cfg_wr(4, 5, 2, 0, M_HOLD);
    for (int k = 1; k <= 12; k++) begin
      tick();
      check("hold_cout", 32'(cout[4]), 1);
      check("hold_pst", 32'(period_start[4]), 0);
    end
    cfg_wr(4, 5, 2, 0, M_NORM);
    for (int k = 1; k <= 7; k++) begin
      tick();
      check("res_cout", 32'(cout[4]), 32'(k <= 4 || k == 7));
      check("res_pst", 32'(period_start[4]), 32'(k == 7));
    end

    // asynchronous reset while counter 4 is HIGH
    #2 reset_n = 1'b0;
    #1;
    check("arst_cout", 32'(cout), 0);
    check("arst_pst", 32'(period_start), 0);
    check("arst_rdy", 32'(cfg_ready), 1);
    check("arst_done", 32'(phase_done), 0);
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("post_cout", 32'(cout), 0);
      check("post_pst", 32'(period_start), 0);
    end

    // out-of-range select is accepted and dropped
    cfg_sel = 3'd7;
    #1;
    check("oor_rdy", 32'(cfg_ready), 1);
    cfg_wr(3'd7, 1, 1, 0, M_NORM);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("oor_cout", 32'(cout), 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
